usb_in_transaction_ctrl: RTL and testbench
==========================================

// Module: usb_in_transaction_ctrl
// PURPOSE
//  Device-side sequencer for USB IN transactions, fed by the token decoder.
//  Accepts a decoded token, checks address, endpoint and CRC status, and requests the
//  packet generator to send DATA0/DATA1, NAK or STALL.
//  For data packets it waits a bounded time for the host ACK.
//  Keeps one DATA0/DATA1 toggle bit per endpoint.
// PARAMETERS
//  NUM_EP       4    number of endpoints (1..16); endp >= NUM_EP is rejected
//  TIMEOUT_CYC  64   cycles allowed in WAIT_HS for the host handshake (>=2)
//  CNT_W        7    timeout counter width; must hold TIMEOUT_CYC
// PORTS
//  clk          in   1       single clock, rising edge
//  reset_L      in   1       asynchronous, active-low reset
//  token_valid  in   1       1-cycle strobe: token fields valid
//  token_pid    in   8       PID byte {~pid[3:0],pid[3:0]}
//  token_addr   in   7       token device address
//  token_endp   in   4       token endpoint number
//  token_err    in   1       CRC5 mismatch flag from token decoder
//  dev_addr     in   7       assigned device address
//  ep_ready     in   NUM_EP  endpoint has a packet loaded for IN
//  ep_stall     in   NUM_EP  endpoint halted
//  toggle_clr   in   NUM_EP  sync clear of endpoint toggle to DATA0
//  tx_req       out  1       level request to packet generator, held until tx_done
//  tx_pid       out  8       PID to transmit; stable while tx_req=1
//  tx_endp      out  4       endpoint whose buffer is sent; stable while tx_req=1
//  tx_done      in   1       1-cycle strobe: packet fully sent
//  hs_valid     in   1       1-cycle strobe: handshake packet received
//  hs_pid       in   8       received handshake PID byte
//  ep_ack       out  NUM_EP  1-cycle one-hot pulse: endpoint data acknowledged
//  timeout_err  out  1       1-cycle pulse: no or bad handshake after a DATA packet
//  busy         out  1       1 in any state other than IDLE
// BEHAVIOUR
//  PID codes: IN 8'h69, DATA0 8'hC3, DATA1 8'h4B, ACK 8'hD2, NAK 8'h5A, STALL 8'h1E.
//  Reset (async, reset_L=0): state IDLE; toggles all 0; outputs cleared as follows:
//   tx_req, ep_ack, timeout_err, busy = 0; tx_pid = 8'h00; tx_endp = 0; counter = 0.
//  FSM states: IDLE, SEND_HS, SEND_DATA, WAIT_HS. All outputs are registered.
//  IDLE, token_valid=1: the token is accepted only if all of these hold:
//   token_err=0, token_pid=8'h69, token_addr=dev_addr, token_endp<NUM_EP.
//   Otherwise the token is dropped with no output activity and the FSM stays in IDLE.
//  On acceptance at edge N, tx_req=1 from cycle N+1 and tx_endp=token_endp. Priority:
//   - ep_stall[e]: tx_pid=STALL, go to SEND_HS.
//   - else !ep_ready[e]: tx_pid=NAK, go to SEND_HS.
//   - else: tx_pid=DATA0 if toggle[e]=0, DATA1 if 1; go to SEND_DATA.
//  SEND_HS: on tx_done, drop tx_req, go to IDLE. Toggle is unchanged.
//  SEND_DATA: on tx_done, drop tx_req, clear counter, go to WAIT_HS.
//  WAIT_HS: counter increments each cycle. Outcomes:
//   - hs_valid with hs_pid=ACK: flip toggle[e], pulse ep_ack[e], go to IDLE.
//   - hs_valid with any other PID: pulse timeout_err, go to IDLE; toggle kept.
//   - counter reaches TIMEOUT_CYC-1 with no hs_valid: pulse timeout_err next edge,
//     go to IDLE; toggle kept.
//   - hs_valid on the timeout cycle: hs_valid wins.
//  token_valid is ignored whenever busy=1; no queueing.
//  A tx_done or hs_valid arriving in a state that does not expect it is ignored.
//  toggle_clr[e] in the same cycle as the ACK for endpoint e: clear wins (toggle=0).
//  reset_L low mid-transaction: immediate return to IDLE, all toggles 0, tx_req=0.
// TESTING
//  1 dev_addr=5, IN ep1 addr5, ep_ready=0010, tx_done, ACK ->
//    tx_pid=C3, then ep_ack=0010, toggle1=1; repeat the transaction -> tx_pid=4B.
//  2 IN ep2, ep_ready[2]=0 -> tx_pid=5A, tx_done, back to IDLE;
//    ep_stall[2]=1 -> tx_pid=1E.
//  3 Token with token_err=1, addr=6 (dev_addr=5), endp=4 (NUM_EP=4), or pid=8'hE1
//    -> tx_req stays 0.
//  4 DATA sent, no hs_valid -> timeout_err pulse exactly TIMEOUT_CYC cycles after
//    tx_done; the next IN resends the same DATA PID.
//  5 hs_valid with ACK on the last timeout cycle -> ep_ack, no timeout_err;
//    toggle_clr with ACK -> next PID C3.
//  6 reset_L=0 during WAIT_HS -> busy=0, tx_req=0 immediately;
//    a new IN token after release -> DATA0.

Source files
------------

// File: rtl/usb_in_transaction_ctrl.sv
// Device-side USB IN transaction sequencer.
// Validates decoded IN tokens and requests DATA0/DATA1, NAK or STALL from the
// packet generator. After a data packet it waits a bounded time for the host
// handshake. It keeps one data toggle bit per endpoint.
module usb_in_transaction_ctrl #(
  parameter int NUM_EP      = 4,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 7
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              token_valid,
  input  logic [7:0]        token_pid,
  input  logic [6:0]        token_addr,
  input  logic [3:0]        token_endp,
  input  logic              token_err,
  input  logic [6:0]        dev_addr,
  input  logic [NUM_EP-1:0] ep_ready,
  input  logic [NUM_EP-1:0] ep_stall,
  input  logic [NUM_EP-1:0] toggle_clr,
  output logic              tx_req,
  output logic [7:0]        tx_pid,
  output logic [3:0]        tx_endp,
  input  logic              tx_done,
  input  logic              hs_valid,
  input  logic [7:0]        hs_pid,
  output logic [NUM_EP-1:0] ep_ack,
  output logic              timeout_err,
  output logic              busy
);

  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  typedef enum logic [1:0] {IDLE, SEND_HS, SEND_DATA, WAIT_HS} state_t;

  state_t            state;
  logic [NUM_EP-1:0] toggle;
  logic [CNT_W-1:0]  cnt;

  logic [NUM_EP-1:0] tok_sel;
  logic [NUM_EP-1:0] cur_sel;
  logic              tok_ok;
  logic              tok_stall;
  logic              tok_ready;
  logic              tok_toggle;
  logic              last_cyc;

  // One-hot endpoint selects. Tokens with endp >= NUM_EP never reach the
  // truncated select, because tok_ok rejects them first.
  assign tok_sel    = NUM_EP'(16'd1 << token_endp);
  assign cur_sel    = NUM_EP'(16'd1 << tx_endp);
  assign tok_ok     = token_valid && !token_err && (token_pid == PID_IN) &&
                      (token_addr == dev_addr) && ({1'b0, token_endp} < 5'(NUM_EP));
  assign tok_stall  = |(ep_stall & tok_sel);
  assign tok_ready  = |(ep_ready & tok_sel);
  assign tok_toggle = |(toggle & tok_sel);
  assign last_cyc   = (cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Transaction FSM with registered outputs and the per-endpoint toggle bits.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state       <= IDLE;
      toggle      <= '0;
      cnt         <= '0;
      tx_req      <= 1'b0;
      tx_pid      <= 8'h00;
      tx_endp     <= 4'd0;
      ep_ack      <= '0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      ep_ack      <= '0;
      timeout_err <= 1'b0;
      toggle      <= toggle & ~toggle_clr;
      unique case (state)
        IDLE: begin
          if (tok_ok) begin
            tx_req  <= 1'b1;
            busy    <= 1'b1;
            tx_endp <= token_endp;
            if (tok_stall) begin
              tx_pid <= PID_STALL;
              state  <= SEND_HS;
            end else if (!tok_ready) begin
              tx_pid <= PID_NAK;
              state  <= SEND_HS;
            end else begin
              tx_pid <= tok_toggle ? PID_DATA1 : PID_DATA0;
              state  <= SEND_DATA;
            end
          end
        end
        SEND_HS: begin
          if (tx_done) begin
            tx_req <= 1'b0;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        SEND_DATA: begin
          if (tx_done) begin
            tx_req <= 1'b0;
            cnt    <= '0;
            state  <= WAIT_HS;
          end
        end
        WAIT_HS: begin
          cnt <= cnt + 1'b1;
          // A handshake that arrives on the last timeout cycle still counts.
          if (hs_valid) begin
            busy  <= 1'b0;
            state <= IDLE;
            if (hs_pid == PID_ACK) begin
              ep_ack <= cur_sel;
              // A same-cycle toggle_clr still forces DATA0.
              toggle <= (toggle ^ cur_sel) & ~toggle_clr;
            end else begin
              timeout_err <= 1'b1;
            end
          end else if (last_cyc) begin
            busy        <= 1'b0;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_in_transaction_ctrl.sv
// Testbench for usb_in_transaction_ctrl: a transaction-level reference model
// checked every cycle, plus hand-computed literal checks for the key scenarios.
module tb_usb_in_transaction_ctrl;

  localparam int NUM_EP  = 4;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              reset_L;
  logic              token_valid;
  logic [7:0]        token_pid;
  logic [6:0]        token_addr;
  logic [3:0]        token_endp;
  logic              token_err;
  logic [6:0]        dev_addr;
  logic [NUM_EP-1:0] ep_ready;
  logic [NUM_EP-1:0] ep_stall;
  logic [NUM_EP-1:0] toggle_clr;
  logic              tx_req;
  logic [7:0]        tx_pid;
  logic [3:0]        tx_endp;
  logic              tx_done;
  logic              hs_valid;
  logic [7:0]        hs_pid;
  logic [NUM_EP-1:0] ep_ack;
  logic              timeout_err;
  logic              busy;

  usb_in_transaction_ctrl #(.NUM_EP(NUM_EP), .TIMEOUT_CYC(TIMEOUT), .CNT_W(7)) dut (
    .clk(clk), .reset_L(reset_L), .token_valid(token_valid), .token_pid(token_pid),
    .token_addr(token_addr), .token_endp(token_endp), .token_err(token_err),
    .dev_addr(dev_addr), .ep_ready(ep_ready), .ep_stall(ep_stall), .toggle_clr(toggle_clr),
    .tx_req(tx_req), .tx_pid(tx_pid), .tx_endp(tx_endp), .tx_done(tx_done),
    .hs_valid(hs_valid), .hs_pid(hs_pid), .ep_ack(ep_ack), .timeout_err(timeout_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the outputs must be after each edge, tracked per
  // transaction (pending request, absolute handshake deadline, toggle per endpoint).
  typedef struct {
    logic              busy;
    logic              req;
    logic [7:0]        pid;
    logic [3:0]        endp;
    logic [NUM_EP-1:0] ack;
    logic              terr;
    logic [NUM_EP-1:0] tog;
    int                cyc;
    int                deadline;
  } model_t;

  function automatic model_t model_reset();
    model_t r;
    r.busy = 1'b0; r.req = 1'b0; r.pid = 8'h00; r.endp = 4'd0;
    r.ack = '0; r.terr = 1'b0; r.tog = '0; r.cyc = 0; r.deadline = 0;
    return r;
  endfunction

  function automatic model_t model_step(input model_t c);
    model_t n;
    int e;
    n = c;
    n.cyc  = c.cyc + 1;
    n.ack  = '0;
    n.terr = 1'b0;
    if (!c.busy) begin
      if (token_valid && !token_err && token_pid == 8'h69 && token_addr == dev_addr &&
          int'(token_endp) < NUM_EP) begin
        e = int'(token_endp);
        n.busy = 1'b1;
        n.req  = 1'b1;
        n.endp = token_endp;
        if (ep_stall[e])       n.pid = 8'h1E;
        else if (!ep_ready[e]) n.pid = 8'h5A;
        else                   n.pid = c.tog[e] ? 8'h4B : 8'hC3;
      end
    end else if (c.req) begin
      if (tx_done) begin
        n.req = 1'b0;
        if (c.pid == 8'hC3 || c.pid == 8'h4B) n.deadline = n.cyc + TIMEOUT;
        else                                  n.busy = 1'b0;
      end
    end else begin
      e = int'(c.endp);
      if (hs_valid) begin
        n.busy = 1'b0;
        if (hs_pid == 8'hD2) begin
          n.tog[e] = ~c.tog[e];
          n.ack[e] = 1'b1;
        end else begin
          n.terr = 1'b1;
        end
      end else if (n.cyc == c.deadline) begin
        n.busy = 1'b0;
        n.terr = 1'b1;
      end
    end
    n.tog = n.tog & ~toggle_clr;
    return n;
  endfunction

  model_t m = model_reset();

  // Advance the model on every clock edge; it resets along with the DUT.
  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) m <= model_reset();
    else          m <= model_step(m);
  end

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("tx_req", 32'(tx_req), 32'(m.req));
      check("busy", 32'(busy), 32'(m.busy));
      check("ep_ack", 32'(ep_ack), 32'(m.ack));
      check("timeout_err", 32'(timeout_err), 32'(m.terr));
      if (m.req) begin
        check("tx_pid", 32'(tx_pid), 32'(m.pid));
        check("tx_endp", 32'(tx_endp), 32'(m.endp));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_token(input logic [7:0] pid, input logic [6:0] addr,
                            input logic [3:0] endp, input logic err);
    token_pid = pid; token_addr = addr; token_endp = endp; token_err = err;
    token_valid = 1'b1;
    tick();
    token_valid = 1'b0;
  endtask

  task automatic finish_tx();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic send_hs(input logic [7:0] pid, input logic [NUM_EP-1:0] clr);
    hs_pid = pid; hs_valid = 1'b1; toggle_clr = clr;
    tick();
    hs_valid = 1'b0; toggle_clr = '0;
  endtask

  task automatic expect_req(input string name, input logic [7:0] pid, input logic [3:0] endp);
    @(negedge clk);
    check({name, "_req"}, 32'(tx_req), 32'd1);
    check({name, "_pid"}, 32'(tx_pid), 32'(pid));
    check({name, "_endp"}, 32'(tx_endp), 32'(endp));
  endtask

  int found;

  initial begin
    reset_L = 1'b0; token_valid = 1'b0; token_pid = 8'h00; token_addr = 7'd0;
    token_endp = 4'd0; token_err = 1'b0; dev_addr = 7'd5; ep_ready = '0;
    ep_stall = '0; toggle_clr = '0; tx_done = 1'b0; hs_valid = 1'b0; hs_pid = 8'h00;
    repeat (3) tick();
    check("rst_tx_req", 32'(tx_req), 32'd0);
    check("rst_tx_pid", 32'(tx_pid), 32'h00);
    check("rst_tx_endp", 32'(tx_endp), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ep_ack", 32'(ep_ack), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    reset_L = 1'b1;
    chk_en  = 1'b1;
    tick();

    // 1: DATA0, ACK, then DATA1 on the repeated transaction
    ep_ready = 4'b0010;
    send_token(8'h69, 7'd5, 4'd1, 1'b0);
    expect_req("t1_data0", 8'hC3, 4'd1);
    tick();
    finish_tx();
    send_hs(8'hD2, '0);
    @(negedge clk);
    check("t1_ep_ack", 32'(ep_ack), 32'b0010);
    send_token(8'h69, 7'd5, 4'd1, 1'b0);
    expect_req("t1_data1", 8'h4B, 4'd1);
    finish_tx();
    send_hs(8'hD2, '0);

    // 2: NAK for a not-ready endpoint, STALL for a halted one
    send_token(8'h69, 7'd5, 4'd2, 1'b0);
    expect_req("t2_nak", 8'h5A, 4'd2);
    send_token(8'h69, 7'd5, 4'd1, 1'b0);
    finish_tx();
    @(negedge clk);
    check("t2_idle", 32'(busy), 32'd0);
    hs_valid = 1'b1; hs_pid = 8'hD2;
    tick();
    hs_valid = 1'b0;
    ep_stall = 4'b0100;
    send_token(8'h69, 7'd5, 4'd2, 1'b0);
    expect_req("t2_stall", 8'h1E, 4'd2);
    finish_tx();
    ep_stall = '0;

    // 3: rejected tokens
    send_token(8'h69, 7'd5, 4'd1, 1'b1);
    @(negedge clk); check("t3_crc", 32'(tx_req), 32'd0);
    send_token(8'h69, 7'd6, 4'd1, 1'b0);
    @(negedge clk); check("t3_addr", 32'(tx_req), 32'd0);
    send_token(8'h69, 7'd5, 4'd4, 1'b0);
    @(negedge clk); check("t3_endp", 32'(tx_req), 32'd0);
    send_token(8'hE1, 7'd5, 4'd1, 1'b0);
    @(negedge clk); check("t3_pid", 32'(busy), 32'd0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;

    // 4: no handshake -> timeout TIMEOUT cycles after tx_done, same PID resent
    send_token(8'h69, 7'd5, 4'd1, 1'b0);
    expect_req("t4_first", 8'hC3, 4'd1);
    finish_tx();
    found = -1;
    for (int i = 0; i < TIMEOUT + 16 && found < 0; i++) begin
      @(negedge clk);
      if (timeout_err) found = i;
    end
    check("t4_timeout_latency", 32'(found), 32'(TIMEOUT));
    send_token(8'h69, 7'd5, 4'd1, 1'b0);
    expect_req("t4_resend", 8'hC3, 4'd1);
    finish_tx();
    send_hs(8'hD2, '0);

    // 5: ACK on the last timeout cycle wins; toggle_clr with ACK wins
    send_token(8'h69, 7'd5, 4'd1, 1'b0);
    expect_req("t5_data1", 8'h4B, 4'd1);
    finish_tx();
    repeat (TIMEOUT - 1) tick();
    send_hs(8'hD2, '0);
    @(negedge clk);
    check("t5_late_ack", 32'(ep_ack), 32'b0010);
    check("t5_no_timeout", 32'(timeout_err), 32'd0);
    send_token(8'h69, 7'd5, 4'd1, 1'b0);
    expect_req("t5_data0", 8'hC3, 4'd1);
    finish_tx();
    send_hs(8'hD2, 4'b0010);
    send_token(8'h69, 7'd5, 4'd1, 1'b0);
    expect_req("t5_after_clr", 8'hC3, 4'd1);
    finish_tx();
    send_hs(8'h5A, '0);
    @(negedge clk);
    check("t5_bad_hs", 32'(timeout_err), 32'd1);
    tick();
    send_token(8'h69, 7'd5, 4'd1, 1'b0);
    finish_tx();
    send_hs(8'hD2, '0);

    // 6: reset in WAIT_HS, then DATA0 after release
    send_token(8'h69, 7'd5, 4'd1, 1'b0);
    expect_req("t6_data1", 8'h4B, 4'd1);
    finish_tx();
    tick();
    reset_L = 1'b0;
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_req", 32'(tx_req), 32'd0);
    repeat (2) tick();
    reset_L = 1'b1;
    tick();
    send_token(8'h69, 7'd5, 4'd1, 1'b0);
    expect_req("t6_data0", 8'hC3, 4'd1);
    finish_tx();
    send_hs(8'hD2, '0);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
